// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered mux/arbiter.
// Combinational only; no latency or backpressure of its own.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Round-robin pointer advance with wrap back to channel 0.
    function automatic int next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin grant: first requester at or above ptr, wrapping to 0.
// Purely combinational, zero latency; grants nothing when no request is present.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any_gnt
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 channel mux (explicit select or round-robin) into one output register, 1-cycle latency.
// in_ready drops on every channel while the held word is not taken (out_valid && !out_ready).
module mux_arb_nx1
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN),
    parameter int MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    logic             load_en;
    logic             xfer;
    logic [SEL_W-1:0] src_idx;
    logic [WIDTH-1:0] src_word;

    assign load_en = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;
            logic [N_IN-1:0]  gnt;
            logic [SEL_W-1:0] gnt_idx;
            logic             any_gnt;
            logic             unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter_n #(.N(N_IN), .W(SEL_W)) u_arb (
                .req     (in_valid),
                .ptr     (rr_ptr),
                .gnt     (gnt),
                .gnt_idx (gnt_idx),
                .any_gnt (any_gnt)
            );

            assign in_ready = (load_en && !rst && any_gnt) ? gnt : '0;
            assign src_idx  = gnt_idx;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rr_ptr <= '0;
                end else if (xfer) begin
                    rr_ptr <= SEL_W'(next_ptr(int'(gnt_idx), N_IN));
                end
            end
        end else begin : g_sel
            // An out-of-range sel matches no channel, so nothing becomes ready.
            always_comb begin
                in_ready = '0;
                for (int i = 0; i < N_IN; i++) begin
                    in_ready[i] = load_en && !rst && (int'(sel) == i);
                end
            end
            assign src_idx = sel;
        end
    endgenerate

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        src_word = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(src_idx) == i) begin
                src_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= src_word;
            out_sel   <= src_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for three mux_arb_nx1 configurations: select N=4, round-robin N=4, select N=3.
module tb_mux_arb_nx1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Select mode, N_IN = 4
    logic [3:0]   v4 = '0;
    logic [127:0] d4 = '0;
    logic [3:0]   r4;
    logic [1:0]   s4 = '0;
    logic         ov4;
    logic [31:0]  od4;
    logic [1:0]   os4;
    logic         ordy4 = 1'b0;

    // Round-robin mode, N_IN = 4
    logic [3:0]   vr = '0;
    logic [127:0] dr = '0;
    logic [3:0]   rr;
    logic [1:0]   sr = '0;
    logic         ovr;
    logic [31:0]  odr;
    logic [1:0]   osr;
    logic         ordyr = 1'b0;

    // Select mode, N_IN = 3
    logic [2:0]   v3 = '0;
    logic [95:0]  d3 = '0;
    logic [2:0]   r3;
    logic [1:0]   s3 = '0;
    logic         ov3;
    logic [31:0]  od3;
    logic [1:0]   os3;
    logic         ordy3 = 1'b0;

    mux_arb_nx1 #(.WIDTH(32), .N_IN(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4), .sel(s4),
        .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4)
    );

    mux_arb_nx1 #(.WIDTH(32), .N_IN(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .in_valid(vr), .in_data(dr), .in_ready(rr), .sel(sr),
        .out_valid(ovr), .out_data(odr), .out_sel(osr), .out_ready(ordyr)
    );

    mux_arb_nx1 #(.WIDTH(32), .N_IN(3), .MODE(0)) u_sel3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(r3), .sel(s3),
        .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq [7] = '{0, 1, 2, 3, 0, 1, 2};

        // Reset values and in_ready gated low while rst is high
        ordy4 = 1'b1;
        vr    = 4'hF;
        #3;
        chk("rst_ov4", 64'(ov4), 64'd0);
        chk("rst_od4", 64'(od4), 64'd0);
        chk("rst_os4", 64'(os4), 64'd0);
        chk("rst_r4",  64'(r4),  64'd0);
        chk("rst_rr",  64'(rr),  64'd0);
        tick();
        tick();
        rst = 1'b0;
        vr  = 4'h0;
        #1;

        // Select mode: sel=2 loads channel 2
        s4        = 2'd2;
        d4[64 +: 32] = 32'hDEADBEEF;
        v4        = 4'b0100;
        ordy4     = 1'b1;
        #1;
        chk("sel_ready", 64'(r4), 64'h4);
        tick();
        chk("sel_od",  64'(od4), 64'hDEADBEEF);
        chk("sel_os",  64'(os4), 64'd2);
        chk("sel_ov",  64'(ov4), 64'd1);

        // Backpressure for three cycles while channel 2 changes
        ordy4        = 1'b0;
        d4[64 +: 32] = 32'h12345678;
        #1;
        chk("bp_ready0", 64'(r4), 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_od",    64'(od4), 64'hDEADBEEF);
            chk("bp_ov",    64'(ov4), 64'd1);
            chk("bp_ready", 64'(r4),  64'h0);
        end
        ordy4 = 1'b1;
        #1;
        chk("bp_rel_ready", 64'(r4), 64'h4);
        tick();
        chk("bp_rel_od", 64'(od4), 64'h12345678);
        chk("bp_rel_ov", 64'(ov4), 64'd1);

        // Drain with no new word; in_ready follows sel even with in_valid low
        v4 = 4'b0000;
        s4 = 2'd0;
        #1;
        chk("sel_ready_novalid", 64'(r4), 64'h1);
        tick();
        chk("drain_ov", 64'(ov4), 64'd0);
        chk("drain_od", 64'(od4), 64'h12345678);
        chk("drain_os", 64'(os4), 64'd2);

        // Round-robin with all four channels valid
        dr    = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        vr    = 4'hF;
        ordyr = 1'b1;
        #1;
        chk("rr_first_ready", 64'(rr), 64'h1);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("rr_seq_sel",  64'(osr), 64'(exp_seq[c]));
            chk("rr_seq_data", 64'(odr), 64'(32'hA0 + exp_seq[c]));
            chk("rr_seq_ov",   64'(ovr), 64'd1);
        end

        // Pointer at 3 with only channels 0,1 requesting: wrap to 0, then 1
        vr = 4'b0011;
        #1;
        chk("rr_wrap_ready", 64'(rr), 64'h1);
        tick();
        chk("rr_wrap_sel", 64'(osr), 64'd0);
        chk("rr_next_ready", 64'(rr), 64'h2);
        tick();
        chk("rr_next_sel",  64'(osr), 64'd1);
        chk("rr_next_data", 64'(odr), 64'hA1);
        chk("rr_wrap2_ready", 64'(rr), 64'h1);

        // Round-robin backpressure blocks every channel
        ordyr = 1'b0;
        #1;
        chk("rr_bp_ready", 64'(rr), 64'h0);
        tick();
        chk("rr_bp_sel", 64'(osr), 64'd1);
        ordyr = 1'b1;
        tick();
        chk("rr_rel_sel", 64'(osr), 64'd0);
        vr = 4'b0000;
        #1;
        chk("rr_idle_ready", 64'(rr), 64'h0);
        tick();
        chk("rr_idle_ov", 64'(ovr), 64'd0);

        // N_IN=3 with out-of-range sel: nothing ready, nothing loads
        d3    = {32'h0000_0C02, 32'h0000_0C01, 32'h0000_0C00};
        v3    = 3'b111;
        s3    = 2'd3;
        ordy3 = 1'b1;
        #1;
        chk("oor_ready", 64'(r3), 64'h0);
        tick();
        tick();
        chk("oor_ov", 64'(ov3), 64'd0);
        s3 = 2'd1;
        #1;
        chk("n3_ready", 64'(r3), 64'h2);
        tick();
        chk("n3_od", 64'(od3), 64'hC01);
        chk("n3_os", 64'(os3), 64'd1);

        // Reset mid-run with a held word, asserted between edges
        s4           = 2'd3;
        d4[96 +: 32] = 32'hCAFEF00D;
        v4           = 4'b1000;
        ordy4        = 1'b1;
        tick();
        ordy4 = 1'b0;
        chk("pre_rst_ov", 64'(ov4), 64'd1);
        chk("pre_rst_od", 64'(od4), 64'hCAFEF00D);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ov",    64'(ov4), 64'd0);
        chk("mid_rst_od",    64'(od4), 64'd0);
        chk("mid_rst_os",    64'(os4), 64'd0);
        chk("mid_rst_r4",    64'(r4),  64'h0);
        chk("mid_rst_r3",    64'(r3),  64'h0);
        tick();
        rst = 1'b0;
        vr  = 4'hF;
        #1;
        chk("rst_ptr_ready", 64'(rr), 64'h1);
        tick();
        chk("rst_ptr_sel", 64'(osr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_nx1.md
Name: mux_arb_nx1

Overview:
- Parametrised successor to the combinational 2:1 32-bit datapath mux.
- Selects one of N_IN WIDTH-bit input channels and forwards it through one registered output stage with a valid/ready handshake.
- Two selection modes:
  - explicit select (MODE_SEL), for ALU-source and writeback-source style use;
  - round-robin arbitration (MODE_RR), for shared-resource requesters in multi-cycle and pipelined variants of the core.

Parameters:
- WIDTH, 32, data bits per channel.
- N_IN, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N_IN), width of sel and out_sel.
- MODE, 0, 0 = MODE_SEL (sel input chooses the channel), 1 = MODE_RR (round-robin grant); sel is ignored in MODE_RR.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  N_IN  per-channel data valid.
- in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_IN  per-channel accept; a transfer on channel i occurs when in_valid[i] && in_ready[i].
- sel  input  SEL_W  channel select, used in MODE_SEL only.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. While rst=1, in_ready=0.
- load_en = !out_valid || out_ready. The output register can accept a new word only when load_en=1. Throughput is 1 word/cycle with out_ready held high.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
- MODE_SEL:
  - in_ready[i] = load_en && (i == sel). This is independent of in_valid.
  - If sel >= N_IN (non-power-of-2 N_IN), no channel is ready and nothing loads.
- MODE_RR:
  - grant = first index g, searched from rr_ptr upward with wrap to 0, such that in_valid[g]=1.
  - in_ready[g] = load_en; all other in_ready bits are 0. If no in_valid bit is set, in_ready=0.
  - On a transfer, rr_ptr <= (g == N_IN-1) ? 0 : g+1. rr_ptr is unchanged otherwise.
- Register update on a transfer: out_data <= selected word, out_sel <= channel index, out_valid <= 1.
- If out_valid && out_ready and no transfer occurs: out_valid <= 0. out_data and out_sel hold their last value.
- Backpressure: while out_valid && !out_ready, out_data, out_sel and out_valid are stable, and all in_ready bits are 0.
- Simultaneous drain and load (out_valid, out_ready and a transfer in the same cycle): the new word replaces the old one. out_valid stays 1 with no bubble.
- Reset mid-transfer: any held word is discarded, outputs return to reset values immediately, and rr_ptr returns to 0.
- in_ready is combinational from out_valid, out_ready, sel/rr_ptr and (MODE_RR only) in_valid. No other combinational input-to-output paths exist.

Decomposition:
- Package mux_pkg holds:
  - MODE_SEL = 0 and MODE_RR = 1 constants;
  - a function next_ptr(g, n) returning the wrapped increment.
- Sub-module rr_arbiter_n (N parameter):
  - inputs: req[N], ptr;
  - outputs: one-hot gnt[N], encoded gnt_idx, any_gnt.
  - Instantiated only under a generate on MODE == MODE_RR.

Test Plan:
- Reset: assert rst mid-run with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 asynchronously, before the next edge; in_ready=0 while rst=1.
- MODE_SEL, N_IN=4, sel=2, in_data ch2=32'hDEADBEEF, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hDEADBEEF, out_sel=2, out_valid=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while ch2 changes to 32'h12345678 -> out_data stays 32'hDEADBEEF and in_ready=0 throughout. When out_ready=1, the new word loads in the same cycle with no bubble.
- MODE_RR, all four channels valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles.
- MODE_RR fairness with wrap: rr_ptr=3, in_valid=4'b0011 -> grant 0, then rr_ptr=1, next grant 1.
- MODE_SEL, N_IN=3, sel=3 (out of range) with all channels valid -> in_ready=3'b000, out_valid stays 0.
